// File: rtl/gate_sweep_pkg.sv
// Shared constants, FSM state type and truth-table function for the gate sweeper.
package gate_sweep_pkg;

  localparam int unsigned N_GATES    = 7;
  localparam int unsigned SETTLE_W   = 4;
  localparam int unsigned VEC_W      = 2;

  localparam int unsigned GIDX_AND   = 0;
  localparam int unsigned GIDX_OR    = 1;
  localparam int unsigned GIDX_NOT   = 2;
  localparam int unsigned GIDX_NAND  = 3;
  localparam int unsigned GIDX_NOR   = 4;
  localparam int unsigned GIDX_XOR   = 5;
  localparam int unsigned GIDX_XNOR  = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Expected gate outputs for one stimulus pair; NOT only looks at a.
  function automatic logic [N_GATES-1:0] gate_expect(input logic a, input logic b);
    logic [N_GATES-1:0] e;
    e            = '0;
    e[GIDX_AND]  = a & b;
    e[GIDX_OR]   = a | b;
    e[GIDX_NOT]  = ~a;
    e[GIDX_NAND] = ~(a & b);
    e[GIDX_NOR]  = ~(a | b);
    e[GIDX_XOR]  = a ^ b;
    e[GIDX_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_expect_lut.sv
// Combinational {a,b} -> expected 7-gate output vector.
module gate_expect_lut
  import gate_sweep_pkg::*;
(
  input  logic               a,
  input  logic               b,
  output logic [N_GATES-1:0] exp_c
);

  assign exp_c = gate_expect(a, b);

endmodule

// File: rtl/logic_gate_sweeper.sv
// Walks all four {a,b} vectors over the gate library and reports per-gate mismatches.
// Optional first-failure capture is built when GATE_SWEEP_FIRST_FAIL_EN is defined.
module logic_gate_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 1,
  parameter logic [N_GATES-1:0] GATE_MASK     = 7'h7F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [N_GATES-1:0] gate_y,
  output logic               gate_a,
  output logic               gate_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_GATES-1:0] fail_mask,
  output logic               first_fail_valid,
  output logic [VEC_W-1:0]   first_fail_vec,
  output logic [N_GATES-1:0] first_fail_y
);

  // Last settle count; unused when SETTLE_CYCLES is zero since SETTLE is skipped.
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? SETTLE_W'(0) : SETTLE_W'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [VEC_W-1:0]     vec;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [N_GATES-1:0]   exp_c;
  logic [N_GATES-1:0]   mis_c;
  logic [N_GATES-1:0]   fail_upd_c;
  logic                 start_acc_c;
  logic                 check_c;

  gate_expect_lut u_lut (
    .a     (gate_a),
    .b     (gate_b),
    .exp_c (exp_c)
  );

  assign mis_c       = (gate_y ^ exp_c) & GATE_MASK;
  assign fail_upd_c  = fail_mask | mis_c;
  assign start_acc_c = (state == ST_IDLE) && start && !abort;
  assign check_c     = (state == ST_CHECK) && !abort;

  // Sweep FSM with vector/settle counters and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
    end else begin
      done <= 1'b0;
      if ((state != ST_IDLE) && abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        pass  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_acc_c) begin
              state     <= ST_DRIVE;
              busy      <= 1'b1;
              vec       <= '0;
              gate_a    <= 1'b0;
              gate_b    <= 1'b0;
              fail_mask <= '0;
              pass      <= 1'b0;
            end
          end
          ST_DRIVE: begin
            settle_cnt <= '0;
            state      <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state <= ST_CHECK;
            end else begin
              settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
          end
          ST_CHECK: begin
            fail_mask <= fail_upd_c;
            if (vec != VEC_W'(3)) begin
              vec              <= vec + VEC_W'(1);
              {gate_a, gate_b} <= vec + VEC_W'(1);
              state            <= ST_DRIVE;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= (fail_upd_c == '0);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            vec   <= '0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef GATE_SWEEP_FIRST_FAIL_EN
  // Latch the first masked mismatch of a sweep; later ones never overwrite it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_y     <= '0;
    end else if (start_acc_c) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_y     <= '0;
    end else if (check_c && !first_fail_valid && (mis_c != '0)) begin
      first_fail_valid <= 1'b1;
      first_fail_vec   <= {gate_a, gate_b};
      first_fail_y     <= gate_y;
    end
  end
`else
  assign first_fail_valid = 1'b0;
  assign first_fail_vec   = '0;
  assign first_fail_y     = '0;
`endif

endmodule

// File: tb/tb_logic_gate_sweeper.sv
// Self-checking bench: three sweepers (default, masked XOR, zero settle) against a gate-fault model.
module tb_logic_gate_sweeper;

  typedef struct {
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] exp_fm;
    logic [1:0] exp_ffvec;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic [2:0] start;
  logic [6:0] s0, s1;

  logic       ga[3], gb[3], busy[3], done[3], pass[3], ffv[3];
  logic [6:0] gy[3], fm[3], ffy[3];
  logic [1:0] ffvec[3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Truth tables from first principles, bit order AND OR NOT NAND NOR XOR XNOR.
  function automatic logic [6:0] golden(input logic a, input logic b);
    logic [6:0] g;
    g[0] = a && b;
    g[1] = a || b;
    g[2] = !a;
    g[3] = !(a && b);
    g[4] = !(a || b);
    g[5] = (a != b);
    g[6] = (a == b);
    return g;
  endfunction

  function automatic logic [6:0] faulty(input logic a, input logic b);
    return (golden(a, b) & ~s0) | s1;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) gy[i] = faulty(ga[i], gb[i]);
  end

  function automatic logic [6:0] inst_mask(input int i);
    return (i == 1) ? 7'h5F : 7'h7F;
  endfunction

  function automatic int inst_settle(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic logic [6:0] model_fail(input logic [6:0] mask);
    logic [6:0] acc;
    logic [1:0] v;
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      v   = 2'(k);
      acc = acc | ((golden(v[1], v[0]) ^ faulty(v[1], v[0])) & mask);
    end
    return acc;
  endfunction

  function automatic void model_first(input logic [6:0] mask, output logic valid,
                                      output logic [1:0] fvec, output logic [6:0] fy);
    logic [1:0] v;
    valid = 1'b0; fvec = '0; fy = '0;
    for (int k = 0; k < 4; k++) begin
      v = 2'(k);
      if (!valid && (((golden(v[1], v[0]) ^ faulty(v[1], v[0])) & mask) != 0)) begin
        valid = 1'b1; fvec = v; fy = faulty(v[1], v[0]);
      end
    end
  endfunction

  logic_gate_sweeper u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .gate_y(gy[0]),
    .gate_a(ga[0]), .gate_b(gb[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_mask(fm[0]), .first_fail_valid(ffv[0]), .first_fail_vec(ffvec[0]),
    .first_fail_y(ffy[0])
  );

  logic_gate_sweeper #(.GATE_MASK(7'h5F)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort), .gate_y(gy[1]),
    .gate_a(ga[1]), .gate_b(gb[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_mask(fm[1]), .first_fail_valid(ffv[1]), .first_fail_vec(ffvec[1]),
    .first_fail_y(ffy[1])
  );

  logic_gate_sweeper #(.SETTLE_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort), .gate_y(gy[2]),
    .gate_a(ga[2]), .gate_b(gb[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .fail_mask(fm[2]), .first_fail_valid(ffv[2]), .first_fail_vec(ffvec[2]),
    .first_fail_y(ffy[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input int i, input string name);
    chk({name, " busy"},  32'(busy[i]), 0);
    chk({name, " done"},  32'(done[i]), 0);
    chk({name, " pass"},  32'(pass[i]), 0);
    chk({name, " ab"},    32'({ga[i], gb[i]}), 0);
    chk({name, " fmask"}, 32'(fm[i]), 0);
    chk({name, " ffv"},   32'(ffv[i]), 0);
    chk({name, " ffvec"}, 32'(ffvec[i]), 0);
    chk({name, " ffy"},   32'(ffy[i]), 0);
  endtask

  // One full sweep on instance i; restart_at > 0 re-pulses start while busy.
  task automatic sweep(input int i, input int restart_at, input string name);
    int         lat, done_lat, ndone, nseq;
    bit         fin;
    logic [1:0] ab, last_ab;
    logic [7:0] seqv;
    logic [6:0] exp_fm;
    logic       e_v;
    logic [1:0] e_vec;
    logic [6:0] e_y;
    exp_fm = model_fail(inst_mask(i));
    model_first(inst_mask(i), e_v, e_vec, e_y);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    chk({name, " busy_rise"}, 32'(busy[i]), 1);
    lat = 1; ndone = 0; done_lat = 0; nseq = 0; seqv = '0; last_ab = '0; fin = 0;
    for (int c = 0; c < 80 && !fin; c++) begin
      ab = {ga[i], gb[i]};
      if (busy[i] && (nseq == 0 || ab != last_ab)) begin
        seqv = {seqv[5:0], ab}; nseq++; last_ab = ab;
      end
      if (done[i]) begin
        ndone++; done_lat = lat;
        chk({name, " pass"},  32'(pass[i]), 32'(exp_fm == 0));
        chk({name, " fmask"}, 32'(fm[i]), 32'(exp_fm));
      end
      if (!busy[i]) fin = 1;
      else begin
        start[i] = (lat == restart_at);
        tick();
        lat++;
      end
    end
    start[i] = 1'b0;
    chk({name, " finished"}, 32'(fin), 1);
    chk({name, " ndone"},    32'(ndone), 1);
    chk({name, " latency"},  32'(done_lat), 32'(4 * (2 + inst_settle(i)) + 1));
    chk({name, " vec_seq"},  32'({nseq[3:0], seqv}), 32'({4'd4, 8'h1B}));
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    chk({name, " ffv"},   32'(ffv[i]), 32'(e_v));
    chk({name, " ffvec"}, 32'(ffvec[i]), 32'(e_vec));
    chk({name, " ffy"},   32'(ffy[i]), 32'(e_y));
`else
    chk({name, " ffv"},   32'(ffv[i]), 0);
    chk({name, " ffvec"}, 32'(ffvec[i]), 0);
    chk({name, " ffy"},   32'(ffy[i]), 0);
`endif
  endtask

  task automatic watch_no_done(input int i, input string name);
    int n;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (done[i]) n++;
      tick();
    end
    chk({name, " no_done"}, 32'(n), 0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{s0: 7'h00, s1: 7'h00, exp_fm: 7'h00, exp_ffvec: 2'b00};
    tbl[1] = '{s0: 7'h20, s1: 7'h00, exp_fm: 7'h20, exp_ffvec: 2'b01};
    tbl[2] = '{s0: 7'h00, s1: 7'h01, exp_fm: 7'h01, exp_ffvec: 2'b00};
    tbl[3] = '{s0: 7'h04, s1: 7'h00, exp_fm: 7'h04, exp_ffvec: 2'b00};
    tbl[4] = '{s0: 7'h00, s1: 7'h40, exp_fm: 7'h40, exp_ffvec: 2'b01};
    tbl[5] = '{s0: 7'h00, s1: 7'h7F, exp_fm: 7'h7F, exp_ffvec: 2'b00};
    tbl[6] = '{s0: 7'h7F, s1: 7'h00, exp_fm: 7'h7F, exp_ffvec: 2'b00};

    rst_n = 1'b0; abort = 1'b0; start = '0; s0 = '0; s1 = '0;
    tick(); tick();
    for (int i = 0; i < 3; i++) chk_reset_vals(i, $sformatf("reset%0d", i));
    rst_n = 1'b1;
    tick();

    // Fault table on the default instance.
    for (int t = 0; t < 7; t++) begin
      s0 = tbl[t].s0; s1 = tbl[t].s1;
      sweep(0, 0, $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d fmask_tbl", t), 32'(fm[0]), 32'(tbl[t].exp_fm));
      chk($sformatf("tbl%0d pass_tbl", t), 32'(pass[0]), 32'(tbl[t].exp_fm == 0));
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      chk($sformatf("tbl%0d ffvec_tbl", t), 32'(ffvec[0]), 32'(tbl[t].exp_ffvec));
`endif
      tick();
    end

    // XOR fault hidden by the gate mask.
    s0 = 7'h20; s1 = '0;
    sweep(1, 0, "mask5f");
    chk("mask5f pass_hold", 32'(pass[1]), 1);
    chk("mask5f fmask_hold", 32'(fm[1]), 0);

    // Zero settle: done at 9.
    s0 = '0;
    sweep(2, 0, "settle0");

    // start while busy is ignored.
    sweep(0, 4, "restart");

    // abort+start together in IDLE keeps IDLE and the previous result.
    abort = 1'b1; start[0] = 1'b1;
    tick();
    abort = 1'b0; start[0] = 1'b0;
    chk("idle_abort_start busy", 32'(busy[0]), 0);
    chk("idle_abort_start pass", 32'(pass[0]), 1);

    // abort during SETTLE of the second vector.
    s1 = 7'h01;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (4) tick();
    chk("abort pre busy", 32'(busy[0]), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy",  32'(busy[0]), 0);
    chk("abort done",  32'(done[0]), 0);
    chk("abort pass",  32'(pass[0]), 0);
    chk("abort fmask", 32'(fm[0]), 32'h01);
    watch_no_done(0, "abort");
    chk("abort fmask_hold", 32'(fm[0]), 32'h01);

    // Reset mid-sweep, then a clean sweep.
    s1 = '0; s0 = 7'h20;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_vals(0, "midreset");
    watch_no_done(0, "midreset");
    s0 = '0;
    sweep(0, 0, "post_reset");

    // Random stuck-at faults on random instances.
    for (int r = 0; r < 24; r++) begin
      int inst;
      inst = int'($urandom_range(0, 2));
      s0 = 7'($urandom & $urandom);
      s1 = 7'($urandom & $urandom & $urandom);
      sweep(inst, 0, $sformatf("rand%0d_u%0d", r, inst));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
